// File: rtl/if_id_hazard_ctrl_pkg.sv
// Shared types and constants for the IF/ID hazard controller.
// Optional feature macro used by the top: HAZARD_PERF_CNT_EN.
package hazard_ctrl_pkg;

  // Controller state: RUN (normal flow) or STALL (multi-cycle load-use hold).
  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Default register-specifier width of the MIPS core.
  localparam int REG_ADDR_W_DEF = 5;

  // Register $zero never carries a real load result, so it never stalls.
  localparam int ZERO_REG = 0;

  // Stall counter width: wide enough to hold LOAD_STALL_CYCLES, at least 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/if_id_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags when the load in EX writes a
// register the instruction in ID is about to read.
module load_use_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hazard
);

  logic rt_not_zero;
  logic rs_match;
  logic rt_match;

  assign rt_not_zero = (ex_rt != REG_ADDR_W'(ZERO_REG));
  assign rs_match    = (ex_rt == id_rs);
  assign rt_match    = id_uses_rt && (ex_rt == id_rt);
  assign hazard      = ex_mem_read && rt_not_zero && (rs_match || rt_match);

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID hazard controller: stalls PC and IF/ID on load-use hazards, flushes
// IF/ID on taken branches/jumps, and freezes everything on mem_wait.
// Outputs are combinational from state and inputs; only state/cnt are registered.
// Handshake/priority per cycle: reset > mem_wait > STALL > hazard > branch/jump > idle.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W        = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_branch_taken,
  input  logic                  id_jump,
  input  logic                  mem_wait,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count,
`endif
  output logic                  stalled
);

  localparam int         CNT_W    = cnt_width(LOAD_STALL_CYCLES);
  localparam bit         MULTI    = (LOAD_STALL_CYCLES > 1);
  localparam [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hazard;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (hazard)
  );

  // State/counter update; frozen while memory is not ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!mem_wait) begin
      case (state)
        RUN: begin
          // A single-cycle stall is fully covered by the hazard cycle itself.
          if (hazard && MULTI) begin
            state <= STALL;
            cnt   <= CNT_INIT;
          end
        end
        STALL: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode in priority order.
  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_wait) begin
      // Freeze: every enable stays low.
      pc_write_en = 1'b0;
    end else if (state == STALL) begin
      id_ex_bubble = 1'b1;
    end else if (hazard) begin
      // Branch/jump ignored: its operands are not ready yet.
      id_ex_bubble = 1'b1;
    end else if (id_branch_taken || id_jump) begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b1;
    end else begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
    end
  end

  assign stalled = (state == STALL) && !reset;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of bubble and flush cycles outside reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (id_ex_bubble && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
      if (if_id_flush && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl: two instances (LOAD_STALL_CYCLES=1 and 3)
// share one stimulus stream; expectations come from a stall-debt model.
module tb_if_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, id_branch_taken, id_jump, mem_wait;

  logic pc1, ifid1, fl1, bb1, st1;
  logic pc3, ifid3, fl3, bb3, st3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
  longint      sc_m1 = 0, fc_m1 = 0, sc_m3 = 0, fc_m3 = 0;
`endif

  int total = 0;
  int bad   = 0;
  int rem1  = 0;
  int rem3  = 0;
  logic [11:0] exp_q[$];

  // Clock and reset block
  always #5 clk = ~clk;

  if_id_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .REG_ADDR_W(5)) u_dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
    .id_jump(id_jump), .mem_wait(mem_wait), .pc_write_en(pc1), .if_id_write_en(ifid1),
    .if_id_flush(fl1), .id_ex_bubble(bb1),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count(sc1), .flush_count(fc1),
`endif
    .stalled(st1)
  );

  if_id_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REG_ADDR_W(5)) u_dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
    .id_jump(id_jump), .mem_wait(mem_wait), .pc_write_en(pc3), .if_id_write_en(ifid3),
    .if_id_flush(fl3), .id_ex_bubble(bb3),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count(sc3), .flush_count(fc3),
`endif
    .stalled(st3)
  );

  // Reference model: 'rem' is the number of stall cycles still owed after this one.
  // Returns {pc_we, if_id_we, flush, bubble, stalled, check_stalled}.
  function automatic logic [5:0] model_step(input int lsc, input int rem, output int rem_next,
                                            input logic hz, input logic br, input logic rst,
                                            input logic mw);
    rem_next = rem;
    if (rst) begin
      rem_next = 0;
      return 6'b001100;
    end
    if (mw) return {4'b0000, (rem > 0), 1'b1};
    if (rem > 0) begin
      rem_next = rem - 1;
      return 6'b000111;
    end
    if (hz) begin
      rem_next = lsc - 1;
      return 6'b000101;
    end
    if (br) return 6'b111001;
    return 6'b110001;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input logic [5:0] e, input logic pc,
                           input logic ifid, input logic fl, input logic bb, input logic st);
    check({tag, ".pc_write_en"},    pc,   e[5]);
    check({tag, ".if_id_write_en"}, ifid, e[4]);
    check({tag, ".if_id_flush"},    fl,   e[3]);
    check({tag, ".id_ex_bubble"},   bb,   e[2]);
    if (e[0]) check({tag, ".stalled"}, st, e[1]);
  endtask

  // Driver: apply one cycle of inputs just after the edge and queue the expectation.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] ert, input logic br,
                       input logic jp, input logic mw, input logic rst);
    logic       hz;
    logic [5:0] e1, e3;
    int         n1, n3;
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mr; ex_rt = ert;
    id_branch_taken = br; id_jump = jp; mem_wait = mw; reset = rst;
    hz = mr && (ert != 0) && ((ert == rs) || (uses && (ert == rt)));
    e1 = model_step(1, rem1, n1, hz, br || jp, rst, mw);
    e3 = model_step(3, rem3, n3, hz, br || jp, rst, mw);
    rem1 = n1;
    rem3 = n3;
    exp_q.push_back({e1, e3});
`ifdef HAZARD_PERF_CNT_EN
    if (rst) begin
      sc_m1 = 0; fc_m1 = 0; sc_m3 = 0; fc_m3 = 0;
    end else begin
      sc_m1 += e1[2]; fc_m1 += e1[3]; sc_m3 += e3[2]; fc_m3 += e3[3];
    end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor / scoreboard: compare outputs mid-cycle against the queued expectation.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_dut("L1", e[11:6], pc1, ifid1, fl1, bb1, st1);
        check_dut("L3", e[5:0],  pc3, ifid3, fl3, bb3, st3);
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; id_branch_taken = 1'b0; id_jump = 1'b0; mem_wait = 1'b0;

    // Reset held three cycles, then release
    repeat (3) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Load-use via rs
    drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Load-use via rt with id_uses_rt
    drive(5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // $zero never stalls; rt match without id_uses_rt never stalls
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    // Hazard with branch, then branch alone, then jump alone
    drive(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(5'd7, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Hazard, then mem_wait for 4 cycles mid-stall, then release
    drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);
    // Reset asserted mid-stall leaves no residual stall
    drive(5'd6, 5'd2, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Hazard re-detected right after a stall restarts the sequence
    drive(5'd3, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(5'd3, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic with small register range to provoke matches
    for (int i = 0; i < 800; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 60) == 0));
    end
    idle(2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

`ifdef HAZARD_PERF_CNT_EN
    check("L1.stall_count", sc1, sc_m1);
    check("L1.flush_count", fc1, fc_m1);
    check("L3.stall_count", sc3, sc_m3);
    check("L3.flush_count", fc3, fc_m3);
`endif

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
